debug_cmd_fsm: RTL and testbench

//  Command front-end of the debug unit, upstream of the register/memory dump FSM. Consumes UART RX bytes.

---
 rtl/debug_cmd_fsm_pkg.sv | 27 ++
 rtl/debug_cmd_fsm_if.sv | 33 +++
 rtl/debug_cmd_fsm_byte_word_packer.sv | 35 +++
 rtl/debug_cmd_fsm.sv | 170 +++++++++++++++++
 tb/tb_debug_cmd_fsm.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_cmd_fsm_pkg.sv
// rtl/debug_cmd_fsm_pkg.sv - command codes, defaults and state type for debug_cmd_fsm (DBG_LOAD_CHECKSUM_EN adds LOAD_CHECK)
package debug_cmd_fsm_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [31:0] DEFAULT_HALT_WORD       = 32'hFFFF_FFFF;
  localparam int          DEFAULT_INST_ADDRS_BITS = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_BYTE,
    ST_LOAD_WRITE,
`ifdef DBG_LOAD_CHECKSUM_EN
    ST_LOAD_CHECK,
`endif
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_SEND,
    ST_SEND_WAIT
  } state_e;

endpackage

// File: rtl/debug_cmd_fsm_if.sv
// rtl/debug_cmd_fsm_if.sv - UART rx, instruction memory and dump handshake bundle for debug_cmd_fsm
interface debug_cmd_fsm_if
  import debug_cmd_fsm_pkg::*;
#(
  parameter int UART_BITS        = 8,
  parameter int INSTRUCTION_BITS = 32,
  parameter int INST_ADDRS_BITS  = DEFAULT_INST_ADDRS_BITS
);
  logic                        i_rx_done;
  logic [UART_BITS-1:0]        i_rx_data;
  logic                        i_halt;
  logic                        i_send_done;
  logic                        o_inst_we;
  logic [INST_ADDRS_BITS-1:0]  o_inst_addr;
  logic [INSTRUCTION_BITS-1:0] o_inst_data;
  logic                        o_proc_enable;
  logic                        o_proc_clear;
  logic                        o_send_start;
  logic                        o_program_loaded;
  logic                        o_load_error;

  modport slave (
    input  i_rx_done, i_rx_data, i_halt, i_send_done,
    output o_inst_we, o_inst_addr, o_inst_data, o_proc_enable, o_proc_clear,
           o_send_start, o_program_loaded, o_load_error
  );

  modport master (
    output i_rx_done, i_rx_data, i_halt, i_send_done,
    input  o_inst_we, o_inst_addr, o_inst_data, o_proc_enable, o_proc_clear,
           o_send_start, o_program_loaded, o_load_error
  );
endinterface

// File: rtl/debug_cmd_fsm_byte_word_packer.sv
// rtl/debug_cmd_fsm_byte_word_packer.sv - shifts rx bytes MSB-first into an instruction word
module byte_word_packer #(
  parameter int UART_BITS        = 8,
  parameter int INSTRUCTION_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        byte_valid_i,
  input  logic [UART_BITS-1:0]        byte_i,
  output logic [INSTRUCTION_BITS-1:0] word_o,
  output logic                        word_valid_o
);
  localparam int BYTES    = INSTRUCTION_BITS / UART_BITS;
  localparam int CNT_BITS = $clog2(BYTES) + 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(BYTES - 1);

  logic [CNT_BITS-1:0]         cnt_q;
  logic [INSTRUCTION_BITS-1:0] word_q;

  // Fires in the same cycle as the final byte so the FSM can write on the next edge.
  assign word_valid_o = byte_valid_i && (cnt_q == LAST);
  assign word_o       = word_q;

  // Byte counter and shift register; a clear or reset drops any partial word.
  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_valid_i) begin
      word_q <= (word_q << UART_BITS) | INSTRUCTION_BITS'(byte_i);
      cnt_q  <= word_valid_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/debug_cmd_fsm.sv
// rtl/debug_cmd_fsm.sv - debug host command decoder: program load, run, single step, dump handoff (DBG_LOAD_CHECKSUM_EN)
module debug_cmd_fsm
  import debug_cmd_fsm_pkg::*;
#(
  parameter int                          UART_BITS        = 8,
  parameter int                          INSTRUCTION_BITS = 32,
  parameter int                          INST_ADDRS_BITS  = DEFAULT_INST_ADDRS_BITS,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD        = DEFAULT_HALT_WORD
) (
  input logic           clk,
  input logic           rst,
  debug_cmd_fsm_if.slave bus
);
  state_e                      state_q, state_d, ret_q, ret_d;
  logic [INST_ADDRS_BITS-1:0]  addr_q, addr_d;
  logic                        loaded_q, loaded_d, err_q, err_d;
  logic                        we_q, en_q, clr_q, start_q;
  logic                        pk_clear, pk_valid, word_valid;
  logic [INSTRUCTION_BITS-1:0] word;
  logic                        rx;
  logic [UART_BITS-1:0]        rxd;
`ifdef DBG_LOAD_CHECKSUM_EN
  logic [UART_BITS-1:0]        xor_q, xor_d;
`endif

  assign rx       = bus.i_rx_done;
  assign rxd      = bus.i_rx_data;
  assign pk_valid = rx && (state_q == ST_LOAD_BYTE);

  byte_word_packer #(
    .UART_BITS       (UART_BITS),
    .INSTRUCTION_BITS(INSTRUCTION_BITS)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pk_clear),
    .byte_valid_i(pk_valid),
    .byte_i      (rxd),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  // Next-state decode: command dispatch, load sequencing and dump handoff.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    addr_d   = addr_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    pk_clear = 1'b0;
`ifdef DBG_LOAD_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx && rxd == UART_BITS'(CMD_LOAD)) begin
          state_d  = ST_LOAD_BYTE;
          addr_d   = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
`ifdef DBG_LOAD_CHECKSUM_EN
          xor_d    = '0;
`endif
        end else if (rx && rxd == UART_BITS'(CMD_RUN) && loaded_q) begin
          state_d = ST_RUN;
        end else if (rx && rxd == UART_BITS'(CMD_STEP) && loaded_q) begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_LOAD_BYTE: begin
`ifdef DBG_LOAD_CHECKSUM_EN
        if (rx) xor_d = xor_q ^ rxd;
`endif
        if (word_valid) state_d = ST_LOAD_WRITE;
      end
      ST_LOAD_WRITE: begin
        if (word == HALT_WORD) begin
`ifdef DBG_LOAD_CHECKSUM_EN
          state_d  = ST_LOAD_CHECK;
`else
          state_d  = ST_IDLE;
          loaded_d = 1'b1;
`endif
        end else if (&addr_q) begin
          // Last location just written and still no HALT_WORD: the program does not fit.
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          loaded_d = 1'b0;
        end else begin
          state_d = ST_LOAD_BYTE;
          addr_d  = addr_q + 1'b1;
        end
      end
`ifdef DBG_LOAD_CHECKSUM_EN
      ST_LOAD_CHECK: begin
        if (rx) begin
          state_d  = ST_IDLE;
          loaded_d = (rxd == xor_q);
          err_d    = (rxd != xor_q);
        end
      end
`endif
      ST_RUN: begin
        if (bus.i_halt) begin
          state_d = ST_SEND;
          ret_d   = ST_IDLE;
        end
      end
      ST_STEP_WAIT: begin
        if (bus.i_halt) begin
          state_d = ST_IDLE;
        end else if (rx && rxd == UART_BITS'(CMD_NEXT)) begin
          state_d = ST_STEP_EXEC;
        end else if (rx && rxd == UART_BITS'(CMD_EXIT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP_EXEC: begin
        state_d = ST_SEND;
        ret_d   = ST_STEP_WAIT;
      end
      ST_SEND:      state_d = ST_SEND_WAIT;
      ST_SEND_WAIT: if (bus.i_send_done) state_d = ret_q;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, counters, sticky flags and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      addr_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      start_q  <= 1'b0;
`ifdef DBG_LOAD_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      we_q     <= (state_d == ST_LOAD_WRITE);
      en_q     <= (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
      start_q  <= (state_d == ST_SEND);
`ifdef DBG_LOAD_CHECKSUM_EN
      xor_q    <= xor_d;
      clr_q    <= (state_d == ST_LOAD_BYTE) || (state_d == ST_LOAD_WRITE) || (state_d == ST_LOAD_CHECK);
`else
      clr_q    <= (state_d == ST_LOAD_BYTE) || (state_d == ST_LOAD_WRITE);
`endif
    end
  end

  assign bus.o_inst_we        = we_q;
  assign bus.o_inst_addr      = addr_q;
  assign bus.o_inst_data      = word;
  assign bus.o_proc_enable    = en_q;
  assign bus.o_proc_clear     = clr_q;
  assign bus.o_send_start     = start_q;
  assign bus.o_program_loaded = loaded_q;
  assign bus.o_load_error     = err_q;
endmodule

// File: tb/tb_debug_cmd_fsm.sv
// tb/tb_debug_cmd_fsm.sv - self-checking bench for debug_cmd_fsm, 10-bit and 2-bit address instances side by side
module tb_debug_cmd_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       halt = 1'b0;
  logic       send_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;

`ifdef DBG_LOAD_CHECKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif

  always #5 clk = ~clk;

  debug_cmd_fsm_if #(.UART_BITS(8), .INSTRUCTION_BITS(32), .INST_ADDRS_BITS(10)) bus0 ();
  debug_cmd_fsm_if #(.UART_BITS(8), .INSTRUCTION_BITS(32), .INST_ADDRS_BITS(2))  bus1 ();

  assign bus0.i_rx_done = rx_done;   assign bus1.i_rx_done = rx_done;
  assign bus0.i_rx_data = rx_data;   assign bus1.i_rx_data = rx_data;
  assign bus0.i_halt = halt;         assign bus1.i_halt = halt;
  assign bus0.i_send_done = send_done; assign bus1.i_send_done = send_done;

  debug_cmd_fsm #(.INST_ADDRS_BITS(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  debug_cmd_fsm #(.INST_ADDRS_BITS(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_WRITE = 2, M_CHECK = 3, M_RUN = 4,
                 M_STEP = 5, M_PULSE = 6, M_DUMP = 7, M_DWAIT = 8;
  int         m_mode[2], m_ret[2], m_nb[2], m_widx[2], m_plen[2];
  logic [7:0] m_cur[2][4];
  logic [7:0] m_prog[2][64];
  logic [31:0] m_word[2];
  bit         m_loaded[2], m_err[2];

  task automatic model_step(input int k, input int ab);
    logic [7:0] x;
    if (!rst) begin
      m_mode[k] = M_IDLE; m_ret[k] = M_IDLE; m_nb[k] = 0; m_widx[k] = 0;
      m_loaded[k] = 0; m_err[k] = 0;
    end else begin
      case (m_mode[k])
        M_IDLE:
          if (rx_done && rx_data == 8'h4C) begin
            m_mode[k] = M_LOAD; m_nb[k] = 0; m_widx[k] = 0; m_plen[k] = 0;
            m_loaded[k] = 0; m_err[k] = 0;
          end else if (rx_done && rx_data == 8'h43 && m_loaded[k]) m_mode[k] = M_RUN;
          else if (rx_done && rx_data == 8'h53 && m_loaded[k]) m_mode[k] = M_STEP;
        M_LOAD:
          if (rx_done) begin
            if (m_plen[k] < 64) m_prog[k][m_plen[k]] = rx_data;
            m_plen[k]++;
            m_cur[k][m_nb[k]] = rx_data;
            m_nb[k]++;
            if (m_nb[k] == 4) begin
              m_word[k] = {m_cur[k][0], m_cur[k][1], m_cur[k][2], m_cur[k][3]};
              m_nb[k] = 0;
              m_mode[k] = M_WRITE;
            end
          end
        M_WRITE:
          if (m_word[k] == 32'hFFFF_FFFF) begin
            if (CKSUM) m_mode[k] = M_CHECK;
            else begin m_mode[k] = M_IDLE; m_loaded[k] = 1; end
          end else if (m_widx[k] == (1 << ab) - 1) begin
            m_mode[k] = M_IDLE; m_err[k] = 1; m_loaded[k] = 0;
          end else begin
            m_widx[k]++; m_mode[k] = M_LOAD;
          end
        M_CHECK:
          if (rx_done) begin
            x = 8'h00;
            for (int i = 0; i < m_plen[k] && i < 64; i++) x = x ^ m_prog[k][i];
            m_mode[k] = M_IDLE;
            m_loaded[k] = (x == rx_data);
            m_err[k] = (x != rx_data);
          end
        M_RUN:   if (halt) begin m_mode[k] = M_DUMP; m_ret[k] = M_IDLE; end
        M_STEP:
          if (halt) m_mode[k] = M_IDLE;
          else if (rx_done && rx_data == 8'h4E) m_mode[k] = M_PULSE;
          else if (rx_done && rx_data == 8'h45) m_mode[k] = M_IDLE;
        M_PULSE: begin m_mode[k] = M_DUMP; m_ret[k] = M_STEP; end
        M_DUMP:  m_mode[k] = M_DWAIT;
        M_DWAIT: if (send_done) m_mode[k] = m_ret[k];
        default: m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 10);
    model_step(1, 2);
  end

  // ---------------- per-cycle compare and activity counters ----------------
  int          en_cnt[2], st_cnt[2], we_cnt[2], last_addr[2];
  int          waddr0[$];
  logic [31:0] wdata0[$];

  task automatic cmp_inst(input int k, input logic we, input int addr, input logic [31:0] data,
                          input logic en, input logic clr, input logic st, input logic ld, input logic er);
    check($sformatf("i%0d we", k), we, m_mode[k] == M_WRITE);
    check($sformatf("i%0d proc_enable", k), en, m_mode[k] == M_RUN || m_mode[k] == M_PULSE);
    check($sformatf("i%0d proc_clear", k), clr, m_mode[k] == M_LOAD || m_mode[k] == M_WRITE || m_mode[k] == M_CHECK);
    check($sformatf("i%0d send_start", k), st, m_mode[k] == M_DUMP);
    check($sformatf("i%0d program_loaded", k), ld, m_loaded[k]);
    check($sformatf("i%0d load_error", k), er, m_err[k]);
    if (m_mode[k] == M_WRITE) begin
      check($sformatf("i%0d inst_addr", k), addr, m_widx[k]);
      check($sformatf("i%0d inst_data", k), data, m_word[k]);
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, bus0.o_inst_we, int'(bus0.o_inst_addr), bus0.o_inst_data, bus0.o_proc_enable,
             bus0.o_proc_clear, bus0.o_send_start, bus0.o_program_loaded, bus0.o_load_error);
    cmp_inst(1, bus1.o_inst_we, int'(bus1.o_inst_addr), bus1.o_inst_data, bus1.o_proc_enable,
             bus1.o_proc_clear, bus1.o_send_start, bus1.o_program_loaded, bus1.o_load_error);
    if (bus0.o_proc_enable) en_cnt[0]++;
    if (bus1.o_proc_enable) en_cnt[1]++;
    if (bus0.o_send_start) st_cnt[0]++;
    if (bus1.o_send_start) st_cnt[1]++;
    if (bus0.o_inst_we) begin
      we_cnt[0]++; last_addr[0] = int'(bus0.o_inst_addr);
      waddr0.push_back(int'(bus0.o_inst_addr)); wdata0.push_back(bus0.o_inst_data);
    end
    if (bus1.o_inst_we) begin we_cnt[1]++; last_addr[1] = int'(bus1.o_inst_addr); end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(1);
    rx_done = 1'b0; tick(3);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic pulse_done();
    send_done = 1'b1; tick(1);
    send_done = 1'b0; tick(2);
  endtask

  task automatic load_test1(input logic [7:0] cks);
    send_byte(8'h4C);
    send_word(32'h0000_002A);
    send_word(32'hFFFF_FFFF);
    if (CKSUM) send_byte(cks);
    tick(2);
  endtask

  int e0, e1, s0, s1, w0, w1, nq;

  initial begin
    // reset
    tick(3);
    check("reset loaded", bus0.o_program_loaded, 1'b0);
    check("reset error", bus0.o_load_error, 1'b0);
    check("reset we", bus0.o_inst_we, 1'b0);
    check("reset addr", bus0.o_inst_addr, 10'd0);
    rst = 1'b1;
    tick(2);

    // run/step/next before any load are ignored
    e0 = en_cnt[0]; e1 = en_cnt[1];
    send_byte(8'h43); send_byte(8'h53); send_byte(8'h4E);
    tick(3);
    check("no-load C/S enable cycles i0", en_cnt[0] - e0, 0);
    check("no-load C/S enable cycles i1", en_cnt[1] - e1, 0);

    // program load of two words
    nq = waddr0.size(); w0 = we_cnt[0];
    load_test1(8'h2A);
    check("load strobes", we_cnt[0] - w0, 2);
    check("load addr0", waddr0[nq], 0);
    check("load data0", wdata0[nq], 32'h0000_002A);
    check("load addr1", waddr0[nq+1], 1);
    check("load data1", wdata0[nq+1], 32'hFFFF_FFFF);
    check("load loaded i0", bus0.o_program_loaded, 1'b1);
    check("load loaded i1", bus1.o_program_loaded, 1'b1);

    // continuous run, halt first sampled 6 edges after the C edge
    e0 = en_cnt[0]; s0 = st_cnt[0];
    rx_data = 8'h43; rx_done = 1'b1; tick(1);
    rx_done = 1'b0; tick(5);
    halt = 1'b1; tick(2);
    halt = 1'b0; tick(2);
    pulse_done();
    tick(2);
    check("run enable cycles", en_cnt[0] - e0, 6);
    check("run send_start pulses", st_cnt[0] - s0, 1);

    // single step: S N N E, then a stray N in IDLE
    e0 = en_cnt[0]; s0 = st_cnt[0]; s1 = st_cnt[1];
    send_byte(8'h53);
    send_byte(8'h4E); pulse_done();
    send_byte(8'h4E); pulse_done();
    send_byte(8'h45);
    send_byte(8'h4E);
    tick(3);
    check("step enable cycles", en_cnt[0] - e0, 2);
    check("step send_start pulses", st_cnt[0] - s0, 2);
    check("step send_start pulses i1", st_cnt[1] - s1, 2);

    // memory full on the 2-bit address instance
    w0 = we_cnt[0]; w1 = we_cnt[1];
    send_byte(8'h4C);
    send_word(32'h0102_0304); send_word(32'h0506_0708);
    send_word(32'h090A_0B0C); send_word(32'h0D0E_0F10);
    tick(2);
    check("full strobes i1", we_cnt[1] - w1, 4);
    check("full last addr i1", last_addr[1], 3);
    check("full error i1", bus1.o_load_error, 1'b1);
    check("full loaded i1", bus1.o_program_loaded, 1'b0);
    check("full strobes i0", we_cnt[0] - w0, 4);
    check("still loading i0", bus0.o_proc_clear, 1'b1);

    // reset after two bytes of a word
    send_byte(8'h12); send_byte(8'h34);
    w0 = we_cnt[0]; w1 = we_cnt[1];
    rst = 1'b0; tick(1);
    rst = 1'b1; tick(2);
    check("mid-reset strobes i0", we_cnt[0] - w0, 0);
    check("mid-reset strobes i1", we_cnt[1] - w1, 0);
    check("mid-reset clear", bus0.o_proc_clear, 1'b0);
    check("mid-reset error i1", bus1.o_load_error, 1'b0);
    check("mid-reset loaded", bus0.o_program_loaded, 1'b0);
    nq = waddr0.size();
    send_byte(8'h4C);
    send_word(32'h1122_3344);
    check("reload addr", waddr0[nq], 0);
    check("reload data", wdata0[nq], 32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    if (CKSUM) send_byte(8'h44);
    tick(2);
    check("reload loaded i0", bus0.o_program_loaded, 1'b1);

`ifdef DBG_LOAD_CHECKSUM_EN
    // checksum mismatch
    load_test1(8'h00);
    check("cksum bad error", bus0.o_load_error, 1'b1);
    check("cksum bad loaded", bus0.o_program_loaded, 1'b0);
    load_test1(8'h2A);
    check("cksum good loaded", bus0.o_program_loaded, 1'b1);
    check("cksum good error", bus0.o_load_error, 1'b0);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
